// File: rtl/warp_issue_scheduler.sv
// Round-robin issue scheduler: picks one eligible warp head per cycle, pops it from
// the instruction buffer and holds it in a registered valid/ready issue slot.
module warp_issue_scheduler #(
  parameter int NUM_WARPS = 8,
  parameter int ARCH_LEN  = 32,
  parameter int INST_BITS = 64,
  parameter int OP_BITS   = 9,
  parameter int NUM_LANES = 16,
  parameter int WID_BITS  = $clog2(NUM_WARPS)
) (
  input  logic                           clock,
  input  logic                           reset,
  input  logic [NUM_WARPS-1:0]           ibuf_valid,
  output logic [NUM_WARPS-1:0]           ibuf_ready,
  input  logic [NUM_WARPS*ARCH_LEN-1:0]  ibuf_pc,
  input  logic [NUM_WARPS*OP_BITS-1:0]   ibuf_op,
  input  logic [NUM_WARPS*NUM_LANES-1:0] ibuf_tmask,
  input  logic [NUM_WARPS*INST_BITS-1:0] ibuf_raw,
  input  logic [NUM_WARPS-1:0]           stall_mask,
  input  logic                           flush_valid,
  input  logic [WID_BITS-1:0]            flush_wid,
  output logic                           issue_valid,
  input  logic                           issue_ready,
  output logic [WID_BITS-1:0]            issue_wid,
  output logic [ARCH_LEN-1:0]            issue_pc,
  output logic [OP_BITS-1:0]             issue_op,
  output logic [NUM_LANES-1:0]           issue_tmask,
  output logic [INST_BITS-1:0]           issue_raw,
  output logic [31:0]                    issue_count
);

  logic                 out_valid_q, out_valid_d;
  logic [WID_BITS-1:0]  out_wid_q,   out_wid_d;
  logic [ARCH_LEN-1:0]  out_pc_q,    out_pc_d;
  logic [OP_BITS-1:0]   out_op_q,    out_op_d;
  logic [NUM_LANES-1:0] out_tmask_q, out_tmask_d;
  logic [INST_BITS-1:0] out_raw_q,   out_raw_d;
  logic [WID_BITS-1:0]  rr_ptr_q,    rr_ptr_d;
  logic [31:0]          issue_count_q, issue_count_d;

  logic                 kill_s;
  logic                 fire_s;
  logic                 can_load_s;
  logic                 pick_valid_s;
  logic [WID_BITS-1:0]  pick_s;
  logic [NUM_WARPS-1:0] eligible_s;

  logic [ARCH_LEN-1:0]  pc_arr_s    [NUM_WARPS];
  logic [OP_BITS-1:0]   op_arr_s    [NUM_WARPS];
  logic [NUM_LANES-1:0] tmask_arr_s [NUM_WARPS];
  logic [INST_BITS-1:0] raw_arr_s   [NUM_WARPS];

  // First set bit of elig at or after start, wrapping; MSB of the result is the found flag.
  function automatic logic [WID_BITS:0] rr_pick(input logic [NUM_WARPS-1:0] elig,
                                                input logic [WID_BITS-1:0]  start);
    logic                found;
    logic                hit;
    logic [WID_BITS-1:0] sel;
    int                  idx;
    found = 1'b0;
    sel   = start;
    for (int i = 0; i < NUM_WARPS; i++) begin
      idx   = int'(start) + i;
      idx   = (idx >= NUM_WARPS) ? idx - NUM_WARPS : idx;
      hit   = ~found & elig[WID_BITS'(idx)];
      sel   = hit ? WID_BITS'(idx) : sel;
      found = found | hit;
    end
    return {found, sel};
  endfunction

  assign kill_s     = flush_valid & out_valid_q & (flush_wid == out_wid_q);
  assign fire_s     = issue_valid & issue_ready;
  assign can_load_s = ~out_valid_q | fire_s | kill_s;

  // The held warp stays ineligible even while it fires: the scoreboard has not seen it yet.
  for (genvar w = 0; w < NUM_WARPS; w++) begin : g_warp
    assign pc_arr_s[w]    = ibuf_pc[ARCH_LEN*w +: ARCH_LEN];
    assign op_arr_s[w]    = ibuf_op[OP_BITS*w +: OP_BITS];
    assign tmask_arr_s[w] = ibuf_tmask[NUM_LANES*w +: NUM_LANES];
    assign raw_arr_s[w]   = ibuf_raw[INST_BITS*w +: INST_BITS];
    assign eligible_s[w]  = ibuf_valid[w] & ~stall_mask[w]
                          & ~(out_valid_q & (out_wid_q == WID_BITS'(w)))
                          & ~(flush_valid & (flush_wid == WID_BITS'(w)));
    assign ibuf_ready[w]  = ~reset & can_load_s & pick_valid_s & (pick_s == WID_BITS'(w));
  end

  assign {pick_valid_s, pick_s} = rr_pick(eligible_s, rr_ptr_q);

  // Next-state for the issue slot, round-robin pointer and issue counter.
  always_comb begin
    out_valid_d   = out_valid_q;
    out_wid_d     = out_wid_q;
    out_pc_d      = out_pc_q;
    out_op_d      = out_op_q;
    out_tmask_d   = out_tmask_q;
    out_raw_d     = out_raw_q;
    rr_ptr_d      = rr_ptr_q;
    issue_count_d = issue_count_q;
    if (can_load_s) begin
      out_valid_d = pick_valid_s;
      if (pick_valid_s) begin
        out_wid_d   = pick_s;
        out_pc_d    = pc_arr_s[pick_s];
        out_op_d    = op_arr_s[pick_s];
        out_tmask_d = tmask_arr_s[pick_s];
        out_raw_d   = raw_arr_s[pick_s];
        rr_ptr_d    = (pick_s == WID_BITS'(NUM_WARPS - 1)) ? {WID_BITS{1'b0}} : pick_s + 1'b1;
      end else begin
        rr_ptr_d    = rr_ptr_q;
      end
    end else begin
      out_valid_d = out_valid_q;
    end
    if (fire_s) begin
      issue_count_d = issue_count_q + 32'd1;
    end else begin
      issue_count_d = issue_count_q;
    end
  end

  // State registers; reset drops any instruction held in the slot.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      out_valid_q   <= 1'b0;
      out_wid_q     <= {WID_BITS{1'b0}};
      out_pc_q      <= {ARCH_LEN{1'b0}};
      out_op_q      <= {OP_BITS{1'b0}};
      out_tmask_q   <= {NUM_LANES{1'b0}};
      out_raw_q     <= {INST_BITS{1'b0}};
      rr_ptr_q      <= {WID_BITS{1'b0}};
      issue_count_q <= 32'd0;
    end else begin
      out_valid_q   <= out_valid_d;
      out_wid_q     <= out_wid_d;
      out_pc_q      <= out_pc_d;
      out_op_q      <= out_op_d;
      out_tmask_q   <= out_tmask_d;
      out_raw_q     <= out_raw_d;
      rr_ptr_q      <= rr_ptr_d;
      issue_count_q <= issue_count_d;
    end
  end

  assign issue_valid = out_valid_q & ~kill_s;
  assign issue_wid   = out_wid_q;
  assign issue_pc    = out_pc_q;
  assign issue_op    = out_op_q;
  assign issue_tmask = out_tmask_q;
  assign issue_raw   = out_raw_q;
  assign issue_count = issue_count_q;

endmodule

// File: tb/tb_warp_issue_scheduler.sv
// Directed bench for warp_issue_scheduler: hand-computed pick order, handshake,
// flush and reset behaviour against a payload generated per warp and generation tag.
module tb_warp_issue_scheduler;
  localparam int NW = 8;
  localparam int AL = 32;
  localparam int IB = 64;
  localparam int OB = 9;
  localparam int NL = 16;
  localparam int WB = 3;

  logic             clock;
  logic             reset;
  logic [NW-1:0]    ibuf_valid;
  logic [NW-1:0]    ibuf_ready;
  logic [NW*AL-1:0] ibuf_pc;
  logic [NW*OB-1:0] ibuf_op;
  logic [NW*NL-1:0] ibuf_tmask;
  logic [NW*IB-1:0] ibuf_raw;
  logic [NW-1:0]    stall_mask;
  logic             flush_valid;
  logic [WB-1:0]    flush_wid;
  logic             issue_valid;
  logic             issue_ready;
  logic [WB-1:0]    issue_wid;
  logic [AL-1:0]    issue_pc;
  logic [OB-1:0]    issue_op;
  logic [NL-1:0]    issue_tmask;
  logic [IB-1:0]    issue_raw;
  logic [31:0]      issue_count;

  logic [7:0] gen;
  int n_cmp;
  int n_err;

  warp_issue_scheduler dut (
    .clock(clock), .reset(reset),
    .ibuf_valid(ibuf_valid), .ibuf_ready(ibuf_ready),
    .ibuf_pc(ibuf_pc), .ibuf_op(ibuf_op), .ibuf_tmask(ibuf_tmask), .ibuf_raw(ibuf_raw),
    .stall_mask(stall_mask), .flush_valid(flush_valid), .flush_wid(flush_wid),
    .issue_valid(issue_valid), .issue_ready(issue_ready), .issue_wid(issue_wid),
    .issue_pc(issue_pc), .issue_op(issue_op), .issue_tmask(issue_tmask),
    .issue_raw(issue_raw), .issue_count(issue_count)
  );

  function automatic logic [AL-1:0] pc_of(input int w, input logic [7:0] g);
    return 32'h0000_1000 + 32'(w) * 32'h40 + {8'h00, g, 16'h0000};
  endfunction
  function automatic logic [OB-1:0] op_of(input int w, input logic [7:0] g);
    return 9'(w * 3 + 1) ^ {1'b0, g};
  endfunction
  function automatic logic [NL-1:0] tmask_of(input int w, input logic [7:0] g);
    return 16'hA5A5 ^ (16'h0001 << w) ^ {g, 8'h00};
  endfunction
  function automatic logic [IB-1:0] raw_of(input int w, input logic [7:0] g);
    return {8'hC0, g, 16'(w), ~pc_of(w, g)};
  endfunction

  for (genvar w = 0; w < NW; w++) begin : g_drv
    assign ibuf_pc[AL*w +: AL]    = pc_of(w, gen);
    assign ibuf_op[OB*w +: OB]    = op_of(w, gen);
    assign ibuf_tmask[NL*w +: NL] = tmask_of(w, gen);
    assign ibuf_raw[IB*w +: IB]   = raw_of(w, gen);
  end

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: run did not finish, got timeout required completion");
    $fatal(1, "watchdog");
  end

  task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic check_issue(input string tag, input int w, input logic [7:0] g);
    check_val({tag, "_valid"}, 64'(issue_valid), 64'd1);
    check_val({tag, "_wid"},   64'(issue_wid),   64'(w));
    check_val({tag, "_pc"},    64'(issue_pc),    64'(pc_of(w, g)));
    check_val({tag, "_op"},    64'(issue_op),    64'(op_of(w, g)));
    check_val({tag, "_tmask"}, 64'(issue_tmask), 64'(tmask_of(w, g)));
    check_val({tag, "_raw"},   issue_raw,        raw_of(w, g));
  endtask

  task automatic step();
    @(posedge clock);
    @(negedge clock);
    #1;
  endtask

  task automatic do_reset();
    @(negedge clock);
    reset = 1'b1;
    ibuf_valid = 8'h00; stall_mask = 8'h00; flush_valid = 1'b0; flush_wid = 3'd0;
    issue_ready = 1'b0; gen = 8'h00;
    @(negedge clock);
    reset = 1'b0;
    #1;
  endtask

  initial begin
    n_cmp = 0; n_err = 0; gen = 8'h00;
    reset = 1'b1; ibuf_valid = 8'hFF; stall_mask = 8'h00;
    flush_valid = 1'b0; flush_wid = 3'd0; issue_ready = 1'b1;

    // Reset state with all heads valid: no pops while reset is high.
    @(negedge clock); #1;
    check_val("rst_ibuf_ready", 64'(ibuf_ready), 64'd0);
    check_val("rst_valid", 64'(issue_valid), 64'd0);
    check_val("rst_wid", 64'(issue_wid), 64'd0);
    check_val("rst_pc", 64'(issue_pc), 64'd0);
    check_val("rst_op", 64'(issue_op), 64'd0);
    check_val("rst_tmask", 64'(issue_tmask), 64'd0);
    check_val("rst_raw", issue_raw, 64'd0);
    check_val("rst_count", 64'(issue_count), 64'd0);
    @(negedge clock);
    reset = 1'b0;
    #1;

    // All warps valid, ready high: 0..7,0,1 back to back, one-hot pops.
    for (int k = 0; k <= 10; k++) begin
      check_val("t1_ibuf_ready", 64'(ibuf_ready), 64'(8'h01 << (k % 8)));
      if (k == 0) check_val("t1_valid0", 64'(issue_valid), 64'd0);
      else check_issue("t1", (k - 1) % 8, 8'h00);
      check_val("t1_count", 64'(issue_count), 64'((k == 0) ? 0 : k - 1));
      step();
    end

    // Warps 2 and 5 valid with rr_ptr at 3: 5 first, then 2.
    do_reset();
    issue_ready = 1'b1; ibuf_valid = 8'h04; #1;
    check_val("t2_pop2", 64'(ibuf_ready), 64'h04);
    step();
    ibuf_valid = 8'h00; #1;
    check_issue("t2_w2", 2, 8'h00);
    step();
    ibuf_valid = 8'h24; #1;
    check_val("t2_empty", 64'(issue_valid), 64'd0);
    check_val("t2_pop5", 64'(ibuf_ready), 64'h20);
    step();
    check_issue("t2_w5", 5, 8'h00);
    check_val("t2_pop2b", 64'(ibuf_ready), 64'h04);
    step();
    check_issue("t2_w2b", 2, 8'h00);
    check_val("t2_count", 64'(issue_count), 64'd2);

    // Backpressure: warp 1 held stable for 4 cycles while heads change.
    do_reset();
    gen = 8'h11; ibuf_valid = 8'h02; issue_ready = 1'b0; #1;
    check_val("t3_pop1", 64'(ibuf_ready), 64'h02);
    step();
    ibuf_valid = 8'h0A;
    for (int k = 0; k < 4; k++) begin
      gen = 8'h20 + 8'(k); #1;
      check_issue("t3_hold", 1, 8'h11);
      check_val("t3_no_pop", 64'(ibuf_ready), 64'd0);
      check_val("t3_count", 64'(issue_count), 64'd0);
      step();
    end
    issue_ready = 1'b1; #1;
    check_val("t3_pop3", 64'(ibuf_ready), 64'h08);
    step();
    check_issue("t3_w3", 3, 8'h23);
    check_val("t3_count1", 64'(issue_count), 64'd1);

    // Single warp: issues every other cycle.
    do_reset();
    ibuf_valid = 8'h10; issue_ready = 1'b1; #1;
    for (int k = 0; k < 6; k++) begin
      check_val("t4_valid", 64'(issue_valid), 64'(k % 2));
      if (k % 2 == 1) check_val("t4_wid", 64'(issue_wid), 64'd4);
      check_val("t4_ibuf_ready", 64'(ibuf_ready), (k % 2 == 0) ? 64'h10 : 64'h00);
      check_val("t4_count", 64'(issue_count), 64'(k / 2));
      step();
    end

    // Flush of held warp 3 while warp 6 loads; then flush of a non-held warp.
    do_reset();
    ibuf_valid = 8'h08; #1;
    step();
    ibuf_valid = 8'h48; flush_valid = 1'b1; flush_wid = 3'd3; issue_ready = 1'b1; #1;
    check_val("t5_killed", 64'(issue_valid), 64'd0);
    check_val("t5_pop6", 64'(ibuf_ready), 64'h40);
    step();
    flush_valid = 1'b0; #1;
    check_issue("t5_w6", 6, 8'h00);
    check_val("t5_count", 64'(issue_count), 64'd0);
    check_val("t5_pop3", 64'(ibuf_ready), 64'h08);
    flush_valid = 1'b1; flush_wid = 3'd3; #1;
    check_val("t5_blocked", 64'(ibuf_ready), 64'h00);
    check_val("t5_not_killed", 64'(issue_valid), 64'd1);
    step();
    flush_valid = 1'b0; #1;
    check_val("t5_drained", 64'(issue_valid), 64'd0);
    check_val("t5_count1", 64'(issue_count), 64'd1);
    check_val("t5_pop3b", 64'(ibuf_ready), 64'h08);

    // Full stall, release warp 7, then asynchronous reset mid-stream.
    do_reset();
    ibuf_valid = 8'hFF; stall_mask = 8'hFF; issue_ready = 1'b1; #1;
    for (int k = 0; k < 3; k++) begin
      check_val("t6_no_pop", 64'(ibuf_ready), 64'd0);
      check_val("t6_idle", 64'(issue_valid), 64'd0);
      step();
    end
    stall_mask = 8'h7F; #1;
    check_val("t6_pop7", 64'(ibuf_ready), 64'h80);
    step();
    check_issue("t6_w7", 7, 8'h00);
    stall_mask = 8'h00; #1;
    check_val("t6_pop0", 64'(ibuf_ready), 64'h01);
    step();
    step();
    check_issue("t6_w1", 1, 8'h00);
    check_val("t6_count", 64'(issue_count), 64'd2);
    #2;
    reset = 1'b1;
    #1;
    check_val("t6_rst_valid", 64'(issue_valid), 64'd0);
    check_val("t6_rst_count", 64'(issue_count), 64'd0);
    check_val("t6_rst_wid", 64'(issue_wid), 64'd0);
    check_val("t6_rst_ibuf_ready", 64'(ibuf_ready), 64'd0);
    @(negedge clock);
    reset = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/warp_issue_scheduler.md
# warp_issue_scheduler

Per-core issue scheduler between the per-warp instruction buffer heads and the single-issue backend. Each cycle it selects one eligible warp head by round-robin, pops it from the instruction buffer, and presents it on a registered valid/ready issue port. Scoreboard stalls and per-warp flushes gate selection. A free-running issue counter provides performance statistics.

## Interface
Parameters:
- NUM_WARPS, 8, number of warps; must be ≥2. WID_BITS = $clog2(NUM_WARPS).
- ARCH_LEN, 32, PC width.
- INST_BITS, 64, raw instruction width.
- OP_BITS, 9, decoded opcode width.
- NUM_LANES, 16, thread mask width.

Ports:
- clock  in  1  sole clock; all state updates on its rising edge.
- reset  in  1  asynchronous, active-high.
- ibuf_valid  in  NUM_WARPS  per-warp head valid.
- ibuf_ready  out  NUM_WARPS  per-warp pop strobe; at most one bit set.
- ibuf_pc  in  NUM_WARPS*ARCH_LEN  head PC. Warp w is at [ARCH_LEN*w +: ARCH_LEN]; every flattened bus below uses the same packing.
- ibuf_op  in  NUM_WARPS*OP_BITS  head opcode.
- ibuf_tmask  in  NUM_WARPS*NUM_LANES  head thread mask.
- ibuf_raw  in  NUM_WARPS*INST_BITS  head raw instruction.
- stall_mask  in  NUM_WARPS  scoreboard or barrier stall; bit set = warp ineligible this cycle.
- flush_valid  in  1  kill request.
- flush_wid  in  WID_BITS  warp to kill.
- issue_valid  out  1  issue slot valid.
- issue_ready  in  1  backend accepts.
- issue_wid  out  WID_BITS  issuing warp.
- issue_pc  out  ARCH_LEN  PC of the issued instruction.
- issue_op  out  OP_BITS  opcode of the issued instruction.
- issue_tmask  out  NUM_LANES  thread mask of the issued instruction.
- issue_raw  out  INST_BITS  raw instruction.
- issue_count  out  32  number of accepted issues; wraps modulo 2^32.

## Operation

State:
- Output register: out_valid, out_wid, and payload fields.
- rr_ptr: WID_BITS wide.
- issue_count: 32 bits.

Signal definitions:
- kill = flush_valid & out_valid & (flush_wid == out_wid).
- fire = issue_valid & issue_ready.
- issue_valid = out_valid & ~kill. The payload outputs are driven directly from the output register.
- can_load = ~out_valid | fire | kill.

Eligibility:
- eligible[w] = ibuf_valid[w] & ~stall_mask[w] & ~(out_valid & out_wid == w) & ~(flush_valid & flush_wid == w).
- A warp held in the output register is never re-selected, even in the cycle it fires, because the scoreboard has not yet observed that instruction. One warp therefore issues at most every other cycle.

Selection:
- Search starts at rr_ptr and proceeds upward, wrapping from NUM_WARPS-1 to 0. The first eligible warp found is pick. pick_valid = |eligible.
- ibuf_ready is a one-hot encoding of pick when can_load & pick_valid; otherwise it is all zeros. ibuf_ready is combinational.

On each clock edge:
- If can_load:
  - out_valid <= pick_valid.
  - If pick_valid, the payload is loaded from warp pick and rr_ptr <= pick+1, wrapping to 0 after NUM_WARPS-1.
  - If ~pick_valid, the payload and rr_ptr hold.
- Otherwise the output register and rr_ptr hold. Payload is stable while issue_valid & ~issue_ready.
- If fire, issue_count increments by 1.

Flush:
- A flush of the held warp drops its instruction. The flush takes priority over issue_ready, so there is no fire and no count.
- A flush of a warp that is not held only blocks that warp's selection for one cycle.
- The block never modifies the instruction buffer contents beyond popping.

## Timing

Reset values:
- issue_valid=0, issue_wid=0, issue_pc=0, issue_op=0, issue_tmask=0, issue_raw=0, issue_count=0.
- ibuf_ready=0 while reset is asserted.
- rr_ptr=0, out_valid=0.

Latency and throughput:
- Latency is 1 cycle: a head popped at edge N appears on issue_* in cycle N+1.
- With issue_ready held high and at least two eligible warps, throughput is one issue per cycle.

Handshake rules:
- Once issue_valid rises, it stays high with a stable payload until fire or kill.
- issue_valid does not depend combinationally on issue_ready.
- ibuf_ready depends combinationally on issue_ready, ibuf_valid, stall_mask and flush.

Boundary conditions:
- No eligible warp while the slot is empty: issue_valid falls to 0, rr_ptr holds.
- Only the held warp is valid: the slot drains, there is one bubble cycle, then that warp is re-issued.
- fire and a new load in the same cycle: both occur with no bubble.
- Reset asserted mid-operation: all state clears immediately (asynchronously), and any instruction in the output register is lost.

## Test plan
- Reset, then all 8 warps valid with issue_ready=1 → issue_wid sequence is 0,1,…,7,0, one per cycle; issue_count=9 after 9 cycles; ibuf_ready is one-hot on each cycle.
- Warps 2 and 5 valid, rr_ptr=3 → warp 5 is picked first, then warp 2; rr_ptr becomes 6, then 3.
- issue_ready=0 for 4 cycles while warp 1 is held → issue_valid, issue_wid=1 and the payload stay stable; ibuf_ready=0 throughout; issue_count is unchanged.
- Only warp 4 valid continuously with issue_ready=1 → warp 4 issues every other cycle, with issue_valid=0 in between.
- Warp 3 held, then flush_valid=1 with flush_wid=3 and issue_ready=1 → no count increment, warp 3 is not selected that cycle, and warp 6 (valid) loads in the same edge.
- stall_mask=0xFF with all ibuf_valid set → no pops and issue_valid stays 0. Clearing stall bit 7 → warp 7 is issued 1 cycle later. Asserting reset mid-stream clears issue_valid and issue_count immediately.
